// File: rtl/cpu_pkg.sv
// Shared fetch-path types: FSM state encoding, redirect source codes, PC register ops.
// Also carries the default reset PC and ack timeout used by fetch_unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } fetch_state_t;

  localparam logic [1:0] PC_SRC_INC  = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP = 2'b01;
  localparam logic [1:0] PC_SRC_REG  = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD = 2'b11;

  // A single op code makes load and increment mutually exclusive by construction.
  typedef enum logic [1:0] {
    PC_OP_HOLD = 2'b00,
    PC_OP_LOAD = 2'b01,
    PC_OP_INC  = 2'b10
  } pc_op_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned TIMEOUT_DEFAULT  = 15;

endpackage

// File: rtl/pc_register.sv
// 32-bit program counter: one-cycle hold/load/increment selected by a single op code.
// No backpressure; increment wraps modulo 2^32.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [31:0] load_val,
  output logic [31:0] pc
);

  pc_op_t op_e;
  assign op_e = pc_op_t'(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (op_e)
        PC_OP_LOAD: pc <= load_val;
        PC_OP_INC:  pc <= pc + 32'd1;
        default:    pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one word per fetch_go, 2 cycles minimum to instr_valid, waits on imem_ack.
// Stalls in REQ until ack; faults to sticky ERR after TIMEOUT ack-less cycles, cleared by err_clr.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_go,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jump_target,
  input  logic [31:0] reg_target,
  input  logic        err_clr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state;
  logic [7:0]   wait_cnt;
  pc_op_t       pc_op;
  logic [31:0]  pc_load_val;

  // PC only moves on an IDLE redirect or an accepted ack, so imem_addr is stable through REQ.
  always_comb begin
    pc_op       = PC_OP_HOLD;
    pc_load_val = jump_target;
    case (state)
      IDLE: begin
        if (pc_write) begin
          case (pc_src)
            PC_SRC_INC:  pc_op = PC_OP_INC;
            PC_SRC_JUMP: begin
              pc_op       = PC_OP_LOAD;
              pc_load_val = jump_target;
            end
            PC_SRC_REG: begin
              pc_op       = PC_OP_LOAD;
              pc_load_val = reg_target;
            end
            default:     pc_op = PC_OP_HOLD;
          endcase
        end
      end
      REQ: begin
        if (imem_ack) pc_op = PC_OP_INC;
      end
      default: pc_op = PC_OP_HOLD;
    endcase
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (pc_op),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A redirect in the same cycle wins; the fetch request is dropped.
          if (fetch_go && !pc_write) begin
            state    <= REQ;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= 8'd0;
          end
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            wait_cnt  <= wait_cnt + 8'd1;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          if (err_clr) begin
            fetch_err <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          imem_req  <= 1'b0;
          busy      <= 1'b0;
          fetch_err <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected instr/pc per fetch, checked on instr_valid.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_go = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] reg_target = 32'h0;
  logic        err_clr = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_go    (fetch_go),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .jump_target (jump_target),
    .reg_target  (reg_target),
    .err_clr     (err_clr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and retire a scoreboard entry on instr_valid.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (instr_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'h0, instr_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc", pc, e.pc);
      end
    end
  endtask

  task automatic redirect(input logic [1:0] src, input logic [31:0] jt, input logic [31:0] rt,
                          input logic [31:0] exp_pc);
    pc_write    = 1'b1;
    pc_src      = src;
    jump_target = jt;
    reg_target  = rt;
    step();
    pc_write = 1'b0;
    m_pc     = exp_pc;
    chk("redirect_pc", pc, m_pc);
    chk("redirect_no_req", {31'h0, imem_req}, 32'h0);
  endtask

  // Fetch with `waits` ack-less REQ cycles; REQ-time pc_write/fetch_go must be ignored.
  task automatic fetch(input int waits, input logic [31:0] data);
    logic [31:0] start_pc;
    exp_t        e;
    start_pc = m_pc;
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk("req_high", {31'h0, imem_req}, 32'h1);
    chk("req_addr", imem_addr, start_pc);
    chk("req_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < waits; i++) begin
      pc_write    = 1'b1;
      pc_src      = PC_SRC_JUMP;
      jump_target = 32'hFFFF_0000;
      fetch_go    = 1'b1;
      step();
      chk("req_hold", {31'h0, imem_req}, 32'h1);
      chk("addr_stable", imem_addr, start_pc);
    end
    pc_write   = 1'b0;
    fetch_go   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    m_pc       = start_pc + 32'd1;
    m_instr    = data;
    e.instr    = data;
    e.pc       = m_pc;
    exp_q.push_back(e);
    step();
    imem_ack = 1'b0;
    chk("done_valid", {31'h0, instr_valid}, 32'h1);
    chk("done_req_low", {31'h0, imem_req}, 32'h0);
    step();
    chk("valid_one_cycle", {31'h0, instr_valid}, 32'h0);
    chk("idle_not_busy", {31'h0, busy}, 32'h0);
    chk("instr_hold", instr, m_instr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err"}, {31'h0, fetch_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_pc    = 32'h0;
    m_instr = 32'h0;
    #1 rst_n = 1'b0;
    #11;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", {31'h0, busy}, 32'h0);

    // First fetch, ack on the first REQ cycle.
    fetch(0, 32'hDEAD_BEEF);
    chk("first_fetch_pc", pc, 32'h1);

    // Jump redirects forward and backward, then fetch from the new PC.
    redirect(PC_SRC_JUMP, 32'h0E, 32'h0, 32'h0E);
    redirect(PC_SRC_JUMP, 32'h0F, 32'h0, 32'h0F);
    redirect(PC_SRC_JUMP, 32'h0D, 32'h0, 32'h0D);
    fetch(2, 32'h1234_5678);
    redirect(PC_SRC_INC, 32'h0, 32'h0, 32'h0F);

    // Register-indirect to the top of the address space, wrap on fetch, then hold.
    redirect(PC_SRC_REG, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    fetch(1, 32'hCAFE_F00D);
    chk("wrap_pc", pc, 32'h0);
    redirect(PC_SRC_HOLD, 32'h55, 32'h66, 32'h0);
    redirect(PC_SRC_REG, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    redirect(PC_SRC_INC, 32'h0, 32'h0, 32'h0);

    // Timeout: 15 ack-less REQ cycles fault to ERR.
    redirect(PC_SRC_JUMP, 32'h40, 32'h0, 32'h40);
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk("to_req", {31'h0, imem_req}, 32'h1);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("to_wait_req", {31'h0, imem_req}, 32'h1);
      chk("to_wait_err", {31'h0, fetch_err}, 32'h0);
    end
    step();
    chk("to_err", {31'h0, fetch_err}, 32'h1);
    chk("to_req_low", {31'h0, imem_req}, 32'h0);
    chk("to_busy", {31'h0, busy}, 32'h1);
    chk("to_pc", pc, m_pc);
    chk("to_instr", instr, m_instr);

    // Late ack and control inputs while in ERR are ignored.
    imem_ack    = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    pc_write    = 1'b1;
    pc_src      = PC_SRC_JUMP;
    jump_target = 32'h99;
    fetch_go    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky", {31'h0, fetch_err}, 32'h1);
      chk("err_pc", pc, m_pc);
      chk("err_instr", instr, m_instr);
    end
    imem_ack = 1'b0;
    pc_write = 1'b0;
    fetch_go = 1'b0;
    err_clr  = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", {31'h0, fetch_err}, 32'h0);
    chk("clr_busy", {31'h0, busy}, 32'h0);
    chk("clr_req", {31'h0, imem_req}, 32'h0);

    // fetch_go and pc_write together: redirect wins, no request issued.
    fetch_go    = 1'b1;
    pc_write    = 1'b1;
    pc_src      = PC_SRC_JUMP;
    jump_target = 32'h77;
    step();
    fetch_go = 1'b0;
    pc_write = 1'b0;
    m_pc     = 32'h77;
    chk("both_pc", pc, m_pc);
    chk("both_no_req", {31'h0, imem_req}, 32'h0);
    chk("both_idle", {31'h0, busy}, 32'h0);
    step();
    chk("both_still_idle", {31'h0, imem_req}, 32'h0);

    // Asynchronous reset in the middle of REQ; pending ack is discarded.
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    step();
    chk("mid_req", {31'h0, imem_req}, 32'h1);
    #2;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    #1;
    chk_reset_outputs("async_reset");
    m_pc    = 32'h0;
    m_instr = 32'h0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_instr", instr, 32'h0);
    imem_ack = 1'b0;

    fetch(0, 32'hA5A5_A5A5);
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the number of REQ cycles without ack before fault; legal range 1..255.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_go  in  1  SHALL request one instruction fetch from the control FSM.
REQ-006 pc_write  in  1  SHALL request a PC redirect.
REQ-007 pc_src  in  2  SHALL select the redirect source: 00 = PC+1, 01 = jump_target, 10 = reg_target, 11 = hold.
REQ-008 jump_target  in  32  SHALL be the branch/jump adder result.
REQ-009 reg_target  in  32  SHALL be the register-indirect target.
REQ-010 err_clr  in  1  SHALL clear a fetch fault.
REQ-011 imem_req  out  1  SHALL be the memory read request.
REQ-012 imem_addr  out  32  SHALL be the word address of the fetch.
REQ-013 imem_ack  in  1  SHALL indicate that imem_rdata is valid.
REQ-014 imem_rdata  in  32  SHALL be the read data.
REQ-015 pc  out  32  SHALL be the current PC register, which feeds the jump adder's inputPC.
REQ-016 instr  out  32  SHALL be the instruction register.
REQ-017 instr_valid  out  1  SHALL be a one-cycle pulse when a new instruction is latched.
REQ-018 busy  out  1  SHALL be high in any state other than IDLE.
REQ-019 fetch_err  out  1  SHALL be a sticky timeout flag.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, REQ, DONE and ERR.
REQ-021 IDLE SHALL go to REQ on fetch_go=1 with pc_write=0.
REQ-022 In IDLE, pc_write=1 SHALL load PC from pc_src; if fetch_go is also high in that cycle, fetch_go SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-023 In IDLE, pc_src=11 with pc_write=1 SHALL leave PC unchanged.
REQ-024 In every state other than IDLE, pc_write and fetch_go SHALL be ignored.
REQ-025 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until the state is exited.
REQ-026 In REQ, imem_ack=1 SHALL be accepted in any cycle, including the first; on that edge instr <= imem_rdata, pc <= pc+1, and the FSM goes to DONE.
REQ-027 DONE SHALL assert instr_valid for exactly one cycle, with imem_req=0, and then return to IDLE.
REQ-028 Latency SHALL be as follows: fetch_go sampled at edge N, imem_req high from N; ack sampled at edge M (M>N) gives instr_valid high in cycle M..M+1; the minimum is 2 cycles from fetch_go to instr_valid.
REQ-029 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-030 When the count reaches TIMEOUT without ack, the FSM SHALL go to ERR with fetch_err=1, imem_req=0, and pc and instr unchanged.
REQ-031 ERR SHALL ignore imem_ack and SHALL return to IDLE on err_clr=1, clearing fetch_err.
REQ-032 err_clr SHALL be ignored in all states other than ERR.
REQ-033 imem_ack arriving in IDLE, DONE or ERR SHALL have no effect.
REQ-034 PC+1 SHALL wrap modulo 2^32, so 32'hFFFFFFFF + 1 = 0.
REQ-035 The PC+1 redirect SHALL use the current pc value.
REQ-036 instr SHALL hold its value until the next accepted ack.

Reset
REQ-037 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, busy=0, fetch_err=0, wait counter=0.
REQ-038 Reset during REQ SHALL drop imem_req asynchronously, and the pending ack SHALL be discarded.
REQ-039 The first edge after rst_n deasserts SHALL be a normal IDLE cycle.

Structure
REQ-040 Shared package cpu_pkg SHALL hold the fetch state enum, the pc_src encodings, and the RESET_PC/TIMEOUT defaults.
REQ-041 There SHALL be one sub-module, pc_register: a 32-bit register with async active-low reset, load, and increment; load and increment SHALL be mutually exclusive by construction.

Verification
REQ-042 Reset, then fetch_go with ack on the first REQ cycle and rdata=32'hDEADBEEF -> instr=DEADBEEF, instr_valid for 1 cycle, pc=1, imem_addr=0 during REQ.
REQ-043 pc=0x0E, pc_write with pc_src=01 and jump_target=0x0F -> pc=0x0F; then jump_target=0x0D -> pc=0x0D; then a fetch -> imem_addr=0x0D.
REQ-044 pc_write with pc_src=10, reg_target=32'hFFFFFFFF, then a fetch with ack -> pc=0; pc_src=11 -> pc unchanged.
REQ-045 fetch_go with ack withheld for TIMEOUT cycles -> fetch_err=1, imem_req=0, pc unchanged; a late ack is ignored; err_clr -> IDLE with fetch_err=0.
REQ-046 fetch_go and pc_write in the same IDLE cycle -> PC loaded, no imem_req; rst_n pulsed low mid-REQ -> all outputs at reset values immediately, pc=RESET_PC.
